// File: rtl/ascon_bridge_pkg.sv
// ascon_bridge_pkg: shared command, state and error-bit definitions for the Ascon stream bridge
package ascon_bridge_pkg;
   typedef enum logic [2:0] {
      C_IDLE, C_KEY, C_NONCE, C_DATA, C_TAG, C_ENC, C_DEC, C_ABORT
   } cmd_e;
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;
   localparam int ERR_START = 0;
   localparam int ERR_LAST  = 1;
endpackage

// File: rtl/bridge_fifo.sv
// bridge_fifo: synchronous FIFO with wrap-bit pointers; push is honoured when full if a pop frees a slot
module bridge_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp, rp;
   logic         wr, rd;
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign dout  = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ascon_stream_bridge.sv
// ascon_stream_bridge: IO_W-bit command/data stream to ascon_aead key/nonce/AXIS/tag ports,
// with a buffered output FIFO, decrypt tag check, abort and sticky error flags
module ascon_stream_bridge
   import ascon_bridge_pkg::*;
#(
   parameter int IO_W       = 8,
   parameter int BLK_W      = 64,
   parameter int KEY_W      = 128,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IO_W-1:0]  in_data,
   input  logic [2:0]       in_cmd,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IO_W-1:0]  out_data,
   output logic             out_is_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             auth_done,
   output logic             auth_fail,
   output logic [1:0]       err,
   output logic             core_start_enc,
   output logic             core_start_dec,
   output logic [KEY_W-1:0] core_key,
   output logic [KEY_W-1:0] core_nonce,
   output logic [KEY_W-1:0] core_tag_in,
   output logic             core_s_tvalid,
   input  logic             core_s_tready,
   output logic [BLK_W-1:0] core_s_tdata,
   output logic             core_s_tlast,
   input  logic             core_m_tvalid,
   output logic             core_m_tready,
   input  logic [BLK_W-1:0] core_m_tdata,
   input  logic             core_m_tlast,
   input  logic [KEY_W-1:0] core_tag_out,
   input  logic             core_tag_valid,
   input  logic             core_busy,
   input  logic             core_auth_fail
);
   localparam int WPB = BLK_W / IO_W;
   localparam int WPK = KEY_W / IO_W;
   localparam int BW  = $clog2(WPB + 1);
   localparam int KW  = $clog2(WPK + 1);
   localparam logic [BW-1:0] B_N    = BW'(WPB);
   localparam logic [BW-1:0] B_LAST = BW'(WPB - 1);
   localparam logic [KW-1:0] K_N    = KW'(WPK);
   localparam logic [KW-1:0] K_LAST = KW'(WPK - 1);
   state_e            state, nxt;
   cmd_e              cmd;
   logic [KW-1:0]     kn, nn, tcnt;
   logic              key_ok, nonce_ok, dec;
   logic [BW-1:0]     bcnt, ser_cnt;
   logic [BLK_W-1:0]  ser, shifted, nxt_blk;
   logic [KEY_W-1:0]  tag;
   logic              tag_v, tag_done, data_done;
   logic              xfer, is_start, start_ok, dat, blk_end, abort, s_hs, m_hs;
   logic              full, empty, push_ok, ser_push, tag_push;
   logic [IO_W:0]     din;
   int                sh;
   assign cmd      = cmd_e'(in_cmd);
   assign in_ready = (cmd == C_ENC || cmd == C_DEC) ? !core_busy :
                     (cmd == C_KEY || cmd == C_NONCE || cmd == C_TAG) ? state != DATA :
                     (cmd == C_DATA) ? !(state == DATA && core_s_tvalid) : 1'b1;
   assign xfer     = in_valid && in_ready;
   assign is_start = xfer && (cmd == C_ENC || cmd == C_DEC) && state == IDLE;
   assign start_ok = is_start && key_ok && nonce_ok;
   assign dat      = xfer && cmd == C_DATA && state == DATA;
   assign blk_end  = dat && (in_last || bcnt == B_LAST);
   assign abort    = xfer && cmd == C_ABORT;
   assign s_hs     = core_s_tvalid && core_s_tready;
   assign m_hs     = core_m_tvalid && core_m_tready;
   assign busy     = state != IDLE;
   assign core_m_tready = ser_cnt == '0 && state != IDLE;
   assign push_ok  = !full || out_ready;
   assign ser_push = ser_cnt != '0 && push_ok;
   // tag words may only follow once every data word has left the serializer
   assign tag_push = ser_cnt == '0 && data_done && tag_v && push_ok;
   assign din      = ser_push ? {1'b0, ser[BLK_W-1 -: IO_W]} : {1'b1, tag[KEY_W-1 -: IO_W]};
   assign out_valid = !empty;
   // a short final block is left-justified so the core sees zero padding in the low bits
   always_comb begin
      shifted = {core_s_tdata[BLK_W-IO_W-1:0], in_data};
      sh      = IO_W * (WPB - 1 - int'(bcnt));
      nxt_blk = in_last ? shifted << sh : shifted;
   end
   always_comb begin
      nxt = state;
      if (start_ok) nxt = DATA;
      if (state == DATA && s_hs && core_s_tlast) nxt = TAIL;
      if (state == TAIL && tag_done && data_done && ser_cnt == '0 && !tag_v) nxt = IDLE;
      if (abort) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         core_key       <= '0;
         core_nonce     <= '0;
         core_tag_in    <= '0;
         kn             <= '0;
         nn             <= '0;
         key_ok         <= 1'b0;
         nonce_ok       <= 1'b0;
         dec            <= 1'b0;
         core_start_enc <= 1'b0;
         core_start_dec <= 1'b0;
         core_s_tvalid  <= 1'b0;
         core_s_tlast   <= 1'b0;
         core_s_tdata   <= '0;
         bcnt           <= '0;
         ser            <= '0;
         ser_cnt        <= '0;
         data_done      <= 1'b0;
         tag            <= '0;
         tag_v          <= 1'b0;
         tcnt           <= '0;
         tag_done       <= 1'b0;
         auth_done      <= 1'b0;
         auth_fail      <= 1'b0;
         err            <= '0;
      end else begin
         core_start_enc <= start_ok && cmd == C_ENC;
         core_start_dec <= start_ok && cmd == C_DEC;
         if (xfer && cmd == C_KEY) begin
            core_key <= {core_key[KEY_W-IO_W-1:0], in_data};
            if (kn != K_N) kn <= kn + 1'b1;
            if (kn == K_LAST) key_ok <= 1'b1;
         end
         if (xfer && cmd == C_NONCE) begin
            core_nonce <= {core_nonce[KEY_W-IO_W-1:0], in_data};
            if (nn != K_N) nn <= nn + 1'b1;
            if (nn == K_LAST) nonce_ok <= 1'b1;
         end
         if (xfer && cmd == C_TAG) core_tag_in <= {core_tag_in[KEY_W-IO_W-1:0], in_data};
         if (is_start && !start_ok) err[ERR_START] <= 1'b1;
         if (start_ok) begin
            dec       <= cmd == C_DEC;
            auth_done <= 1'b0;
            auth_fail <= 1'b0;
            data_done <= 1'b0;
            tag_done  <= 1'b0;
            tag_v     <= 1'b0;
         end
         if (dat) begin
            core_s_tdata <= nxt_blk;
            bcnt         <= blk_end ? '0 : bcnt + 1'b1;
            if (blk_end) core_s_tvalid <= 1'b1;
            if (blk_end) core_s_tlast <= in_last;
            if (in_last && bcnt != B_LAST) err[ERR_LAST] <= 1'b1;
         end
         if (s_hs) core_s_tvalid <= 1'b0;
         if (m_hs) begin
            ser     <= core_m_tdata;
            ser_cnt <= B_N;
            if (core_m_tlast) data_done <= 1'b1;
         end else if (ser_push) begin
            ser     <= {ser[BLK_W-IO_W-1:0], {IO_W{1'b0}}};
            ser_cnt <= ser_cnt - 1'b1;
         end
         if (core_tag_valid && dec) begin
            auth_done <= 1'b1;
            auth_fail <= core_auth_fail;
            tag_done  <= 1'b1;
         end else if (core_tag_valid) begin
            tag   <= core_tag_out;
            tag_v <= 1'b1;
            tcnt  <= '0;
         end else if (tag_push) begin
            tag  <= {tag[KEY_W-IO_W-1:0], {IO_W{1'b0}}};
            tcnt <= tcnt + 1'b1;
            if (tcnt == K_LAST) tag_v <= 1'b0;
            if (tcnt == K_LAST) tag_done <= 1'b1;
         end
         if (abort) begin
            core_s_tdata  <= '0;
            core_s_tvalid <= 1'b0;
            core_s_tlast  <= 1'b0;
            bcnt          <= '0;
            ser           <= '0;
            ser_cnt       <= '0;
            tag_v         <= 1'b0;
            tcnt          <= '0;
            data_done     <= 1'b0;
            tag_done      <= 1'b0;
            err           <= '0;
         end
      end
   end
   bridge_fifo #(.W(IO_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .push  (ser_push || tag_push),
      .pop   (out_ready),
      .din   (din),
      .dout  ({out_is_tag, out_data}),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_ascon_stream_bridge.sv
// tb_ascon_stream_bridge: random stream stimulus against a stubbed core, with scoreboard queues
// for core-side blocks and pin-side output words
module tb_ascon_stream_bridge;
   import ascon_bridge_pkg::*;
   localparam logic [63:0]  KS   = 64'h0F1E2D3C4B5A6978;
   localparam logic [127:0] TAGC = 128'hC0FFEE00112233445566778899AABBCC;
   logic         clk, rst;
   logic [7:0]   in_data, out_data;
   logic [2:0]   in_cmd;
   logic         in_last, in_valid, in_ready, out_is_tag, out_valid, out_ready;
   logic         busy, auth_done, auth_fail, core_start_enc, core_start_dec;
   logic [1:0]   err;
   logic [127:0] core_key, core_nonce, core_tag_in, core_tag_out;
   logic         core_s_tvalid, core_s_tready, core_s_tlast;
   logic [63:0]  core_s_tdata, core_m_tdata;
   logic         core_m_tvalid, core_m_tready, core_m_tlast;
   logic         core_tag_valid, core_busy, core_auth_fail;
   logic         hold, stub_af, arm;
   logic [64:0]  mq[$];
   logic [64:0]  blk_q[$];
   logic [8:0]   out_q[$];
   logic [7:0]   wq[$];
   logic [64:0]  e_blk;
   logic [8:0]   e_out;
   logic [127:0] exp_t;
   int           pass, tot, enc_n, dec_n;
   ascon_stream_bridge dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_cmd(in_cmd), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_is_tag(out_is_tag),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .auth_done(auth_done),
      .auth_fail(auth_fail), .err(err), .core_start_enc(core_start_enc),
      .core_start_dec(core_start_dec), .core_key(core_key), .core_nonce(core_nonce),
      .core_tag_in(core_tag_in), .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
      .core_s_tdata(core_s_tdata), .core_s_tlast(core_s_tlast), .core_m_tvalid(core_m_tvalid),
      .core_m_tready(core_m_tready), .core_m_tdata(core_m_tdata), .core_m_tlast(core_m_tlast),
      .core_tag_out(core_tag_out), .core_tag_valid(core_tag_valid), .core_busy(core_busy),
      .core_auth_fail(core_auth_fail)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign core_tag_out   = TAGC;
   assign core_auth_fail = stub_af;
   // stub core: XORs each block with a fixed keystream, tag one cycle after its last output block
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         core_m_tvalid  <= 1'b0;
         core_m_tdata   <= '0;
         core_m_tlast   <= 1'b0;
         core_s_tready  <= 1'b0;
         core_tag_valid <= 1'b0;
         core_busy      <= 1'b0;
         arm            <= 1'b0;
      end else begin
         if (core_s_tvalid && core_s_tready) begin
            mq.push_back({core_s_tlast, core_s_tdata ^ KS});
            if (core_s_tlast) core_busy <= 1'b1;
         end
         core_tag_valid <= arm;
         if (arm) begin
            arm       <= 1'b0;
            core_busy <= 1'b0;
         end
         if (core_m_tvalid && core_m_tready) begin
            if (mq[0][64]) arm <= 1'b1;
            void'(mq.pop_front());
         end
         core_m_tvalid <= mq.size() != 0;
         if (mq.size() != 0) begin
            core_m_tdata <= mq[0][63:0];
            core_m_tlast <= mq[0][64];
         end
         core_s_tready <= $urandom_range(0, 3) != 0;
      end
   end
   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      tot++;
      if (a !== e) $display("FAIL %s: got %h expected %h", nm, a, e);
      else pass++;
   endtask
   always @(negedge clk) begin
      if (core_start_enc) enc_n++;
      if (core_start_dec) dec_n++;
      if (!rst && core_s_tvalid && core_s_tready) begin
         if (blk_q.size() == 0) begin
            tot++;
            $display("FAIL blk_extra: got %h last=%b with nothing expected", core_s_tdata, core_s_tlast);
         end else begin
            e_blk = blk_q.pop_front();
            chk("core_s_block", {core_s_tlast, core_s_tdata}, e_blk);
         end
      end
      if (!rst && out_valid && out_ready) begin
         if (out_q.size() == 0) begin
            tot++;
            $display("FAIL out_extra: got %h tag=%b with nothing expected", out_data, out_is_tag);
         end else begin
            e_out = out_q.pop_front();
            chk("out_word", {out_is_tag, out_data}, e_out);
         end
      end
   end
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end
   task automatic send(input cmd_e c, input logic [7:0] d, input logic l);
      int n = 0;
      in_cmd = c;
      in_data = d;
      in_last = l;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tot++;
         $display("FAIL in_ready_timeout: cmd %0d not accepted within %0d cycles", c, n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_cmd = C_IDLE;
      in_last = 1'b0;
   endtask
   task automatic model(input bit dec);
      logic [63:0]  b, c;
      logic [127:0] t;
      int           n;
      n = wq.size();
      for (int k = 0; k * 8 < n; k++) begin
         b = '0;
         for (int j = 0; j < 8; j++) if (k * 8 + j < n) b[63-8*j -: 8] = wq[k*8+j];
         blk_q.push_back({k * 8 + 8 >= n, b});
         c = b ^ KS;
         for (int j = 0; j < 8; j++) out_q.push_back({1'b0, c[63-8*j -: 8]});
      end
      if (!dec) begin
         t = TAGC;
         for (int j = 0; j < 16; j++) out_q.push_back({1'b1, t[127-8*j -: 8]});
      end
   endtask
   task automatic wait_idle();
      int n = 0;
      while (n < 3000 && (busy || out_valid || out_q.size() != 0 || blk_q.size() != 0)) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", n < 3000, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic send_words();
      for (int i = 0; i < wq.size(); i++) send(C_DATA, wq[i], i == wq.size() - 1);
   endtask
   task automatic run_op(input bit dec);
      model(dec);
      send(dec ? C_DEC : C_ENC, 8'h00, 1'b0);
      send_words();
      wait_idle();
   endtask
   initial begin
      int n0, len;
      bit md;
      pass = 0; tot = 0; enc_n = 0; dec_n = 0;
      rst = 1'b1; in_valid = 1'b0; in_cmd = C_IDLE; in_data = '0; in_last = 1'b0;
      hold = 1'b0; stub_af = 1'b0; exp_t = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_m_tready", core_m_tready, 0);
      chk("rst_s_tvalid", core_s_tvalid, 0);
      chk("rst_key", core_key, 0);
      for (int i = 0; i < 8; i++) send(C_KEY, 8'(i), 1'b0);
      n0 = enc_n;
      send(C_ENC, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("partial_key_err", err, 2'b01);
      chk("partial_key_busy", busy, 0);
      chk("partial_key_no_pulse", enc_n, n0);
      for (int i = 8; i < 16; i++) send(C_KEY, 8'(i), 1'b0);
      for (int i = 0; i < 16; i++) send(C_NONCE, 8'(16 + i), 1'b0);
      chk("key_value", core_key, 128'h000102030405060708090A0B0C0D0E0F);
      chk("nonce_value", core_nonce, 128'h101112131415161718191A1B1C1D1E1F);
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back(8'(i));
      model(1'b0);
      send(C_ENC, 8'h00, 1'b0);
      chk("start_enc_pulse", core_start_enc, 1);
      chk("start_busy", busy, 1);
      send_words();
      wait_idle();
      chk("enc_err_sticky", err, 2'b01);
      chk("enc_auth_done", auth_done, 0);
      send(C_ABORT, 8'h00, 1'b0);
      chk("abort_clears_err", err, 0);
      for (int i = 0; i < 16; i++) begin
         in_data = 8'($urandom);
         exp_t = {exp_t[119:0], in_data};
         send(C_TAG, in_data, 1'b0);
      end
      chk("exp_tag_value", core_tag_in, exp_t);
      stub_af = 1'b1;
      wq.delete();
      wq.push_back(8'hAA); wq.push_back(8'hBB); wq.push_back(8'hCC);
      n0 = dec_n;
      run_op(1'b1);
      chk("dec_pulse", dec_n, n0 + 1);
      chk("short_block_err", err, 2'b10);
      chk("dec_auth_done", auth_done, 1);
      chk("dec_auth_fail", auth_fail, 1);
      for (int it = 0; it < 10; it++) begin
         send(C_ABORT, 8'h00, 1'b0);
         md = 1'($urandom);
         len = 1 + int'($urandom_range(0, 19));
         stub_af = 1'($urandom);
         wq.delete();
         for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
         run_op(md);
         chk("rand_err", err, {len % 8 != 0, 1'b0});
         chk("rand_auth_done", auth_done, md);
         chk("rand_auth_fail", auth_fail, md & stub_af);
      end
      send(C_ABORT, 8'h00, 1'b0);
      hold = 1'b1;
      wq.delete();
      for (int i = 0; i < 24; i++) wq.push_back(8'($urandom));
      model(1'b0);
      send(C_ENC, 8'h00, 1'b0);
      send_words();
      repeat (80) @(posedge clk);
      #1;
      chk("hold_m_tready", core_m_tready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_nothing_popped", out_q.size(), 40);
      hold = 1'b0;
      wait_idle();
      send(C_ENC, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) send(C_DATA, 8'($urandom), 1'b0);
      send(C_ABORT, 8'h00, 1'b0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_s_tvalid", core_s_tvalid, 0);
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back(8'($urandom));
      n0 = enc_n;
      run_op(1'b0);
      chk("restart_pulse", enc_n, n0 + 1);
      chk("restart_err", err, 0);
      send(C_ENC, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) send(C_DATA, 8'($urandom), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_key", core_key, 0);
      chk("midrst_in_ready", in_ready, 1);
      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end
endmodule
